// File: rtl/comp2s_pkg.sv
// -----------------------------------------------------------------------------
// comp2s_pkg
// Shared definitions for the comp2s two's-complement pipeline.
// The operation modes are listed here so that the core, the top level and any
// upstream mode generator all use the same encoding.
// -----------------------------------------------------------------------------
package comp2s_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_PASS = 2'b00;  // out = x
    localparam mode_t MODE_NEG  = 2'b01;  // out = -x
    localparam mode_t MODE_ABS  = 2'b10;  // out = |x|
    localparam mode_t MODE_SM   = 2'b11;  // out = sign-magnitude form of x

endpackage

// File: rtl/comp2s_if.sv
// -----------------------------------------------------------------------------
// comp2s_if
// Streaming bus between the multiplier front-end, the comp2s pipeline and the
// accumulator. It carries two valid/ready links:
//   in_valid / in_ready  with payload {mode, data_in}  (front-end -> pipeline)
//   out_valid / out_ready with payload {data_out, ovf} (pipeline -> accumulator)
// Modports:
//   master : the side that feeds samples in and consumes results
//   slave  : the pipeline itself
// -----------------------------------------------------------------------------
interface comp2s_if
    import comp2s_pkg::*;
#(
    parameter int N = 16
);
    logic         in_valid;
    logic         in_ready;
    mode_t        mode;
    logic [N-1:0] data_in;

    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] data_out;
    logic         ovf;

    modport master (
        output in_valid,
        output mode,
        output data_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  data_out,
        input  ovf
    );

    modport slave (
        input  in_valid,
        input  mode,
        input  data_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output data_out,
        output ovf
    );

endinterface

// File: rtl/comp2s_core.sv
// -----------------------------------------------------------------------------
// comp2s_core
// Purely combinational two's-complement operator: {mode, x} -> {y, ovf}.
//   MODE_PASS : y = x,                               ovf = 0
//   MODE_NEG  : y = -x (mod 2^N)
//   MODE_ABS  : y = |x|
//   MODE_SM   : y = {sign, |x| in N-1 bits}
// The most-negative code MN = 2^(N-1) has no positive counterpart. For NEG
// and ABS it raises ovf and yields MAXP when SAT=1, or wraps to MN when SAT=0.
// For SM it raises ovf and always yields {1, all ones}, the largest
// representable negative magnitude.
// Zero maps to zero in every mode, so SM never produces a negative zero.
// Ports:
//   mode : operation select
//   x    : two's-complement operand
//   y    : result
//   ovf  : x hit the most-negative corner case in a mode that transforms it
// -----------------------------------------------------------------------------
module comp2s_core
    import comp2s_pkg::*;
#(
    parameter int N   = 16,
    parameter bit SAT = 1'b1
) (
    input  mode_t               mode,
    input  logic signed [N-1:0] x,
    output logic signed [N-1:0] y,
    output logic                ovf
);

    localparam logic signed [N-1:0] MN   = {1'b1, {(N-1){1'b0}}};
    localparam logic signed [N-1:0] MAXP = {1'b0, {(N-1){1'b1}}};
    localparam logic signed [N-1:0] SM_MN = {N{1'b1}};

    // Result for -MN / |MN| when the true value is out of range.
    function automatic logic signed [N-1:0] sat_mn(input logic sat_en);
        return sat_en ? MAXP : MN;
    endfunction

    // Sign-magnitude form of a value that is known not to be MN, so its
    // magnitude fits in N-1 bits.
    function automatic logic signed [N-1:0] to_sm(input logic signed [N-1:0] v,
                                                   input logic signed [N-1:0] neg_v);
        return v[N-1] ? {1'b1, neg_v[N-2:0]} : v;
    endfunction

    logic signed [N-1:0] neg_x;
    logic                is_mn;

    // Negation wraps modulo 2^N; the MN case is patched below.
    assign neg_x = -x;
    assign is_mn = (x == MN);

    always_comb begin
        y   = x;
        ovf = 1'b0;
        case (mode)
            MODE_PASS: begin
                y   = x;
                ovf = 1'b0;
            end
            MODE_NEG: begin
                ovf = is_mn;
                y   = is_mn ? sat_mn(SAT) : neg_x;
            end
            MODE_ABS: begin
                ovf = is_mn;
                if (is_mn) begin
                    y = sat_mn(SAT);
                end else begin
                    y = x[N-1] ? neg_x : x;
                end
            end
            MODE_SM: begin
                ovf = is_mn;
                y   = is_mn ? SM_MN : to_sm(x, neg_x);
            end
            default: begin
                y   = x;
                ovf = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/comp2s_pipe.sv
// -----------------------------------------------------------------------------
// comp2s_pipe
// Two-stage valid/ready pipeline around comp2s_core, plus an overflow event
// counter.
//   S1 (_p1) captures {mode, data_in} from the input link.
//   S2 (_p2) holds the computed {data_out, ovf} presented on the output link.
// Latency is two cycles and throughput is one sample per cycle when the
// output is not stalled. in_ready is combinational from out_ready (no skid
// buffer), so a full pipeline accepts a new sample in the same cycle the
// result leaves.
// Parameters:
//   N     : data width in bits (>= 2)
//   SAT   : 1 saturates -MN/|MN| to MAXP, 0 wraps to MN
//   CNT_W : width of the overflow event counter
// Ports:
//   clk     : rising-edge clock
//   rst     : asynchronous active-high reset; empties both stages and clears
//             data_out, ovf and ovf_cnt immediately
//   bus     : streaming interface (slave side)
//   clr_cnt : synchronous clear of ovf_cnt; wins over a same-cycle event
//   ovf_cnt : saturating count of delivered samples flagged ovf
// -----------------------------------------------------------------------------
module comp2s_pipe
    import comp2s_pkg::*;
#(
    parameter int N     = 16,
    parameter bit SAT   = 1'b1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    comp2s_if.slave          bus,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] ovf_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Increment that sticks at the all-ones code instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_ONE;
    endfunction

    logic                vld_p1;
    mode_t               mode_p1;
    logic signed [N-1:0] data_p1;

    logic                vld_p2;
    logic signed [N-1:0] data_p2;
    logic                ovf_p2;

    logic signed [N-1:0] y_core;
    logic                ovf_core;

    logic                s2_load;
    logic                s1_load;
    logic                ovf_evt;

    // S2 can take a new value when it is empty or its content leaves now;
    // S1 can take one when it is empty or its content moves into S2.
    assign s2_load      = !vld_p2 || bus.out_ready;
    assign bus.in_ready = !vld_p1 || s2_load;
    assign s1_load      = bus.in_valid && bus.in_ready;

    // ---- stage S1: capture input sample ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else if (bus.in_ready) begin
            vld_p1 <= bus.in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (s1_load) begin
            mode_p1 <= bus.mode;
            data_p1 <= bus.data_in;
        end
    end

    comp2s_core #(
        .N   (N),
        .SAT (SAT)
    ) u_core (
        .mode (mode_p1),
        .x    (data_p1),
        .y    (y_core),
        .ovf  (ovf_core)
    );

    // ---- stage S2: computed result, held while stalled ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p2  <= 1'b0;
            data_p2 <= '0;
            ovf_p2  <= 1'b0;
        end else if (s2_load) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                data_p2 <= y_core;
                ovf_p2  <= ovf_core;
            end
        end
    end

    assign bus.out_valid = vld_p2;
    assign bus.data_out  = data_p2;
    assign bus.ovf       = ovf_p2;

    // ---- overflow event counter, counts on delivery ----
    assign ovf_evt = vld_p2 && bus.out_ready && ovf_p2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_cnt <= '0;
        end else if (clr_cnt) begin
            ovf_cnt <= '0;
        end else if (ovf_evt) begin
            ovf_cnt <= sat_inc(ovf_cnt);
        end
    end

endmodule

// File: tb/tb_comp2s_pipe.sv
// -----------------------------------------------------------------------------
// tb_comp2s_pipe
// Drives two comp2s_pipe instances with identical stimulus:
//   dut_a : N=16, SAT=1, CNT_W=2
//   dut_b : N=16, SAT=0, CNT_W=16
// A reference model tracks accepted samples in a queue and computes the
// expected result of each with integer arithmetic.
// -----------------------------------------------------------------------------
module tb_comp2s_pipe;
    import comp2s_pkg::*;

    localparam int N = 16;

    logic         clk       = 1'b0;
    logic         rst       = 1'b1;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b0;
    logic         clr_cnt   = 1'b0;
    logic [1:0]   mode      = 2'b00;
    logic [N-1:0] data_in   = '0;
    logic [1:0]   ovf_cnt_a;
    logic [15:0]  ovf_cnt_b;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    comp2s_if #(.N(N)) bus_a ();
    comp2s_if #(.N(N)) bus_b ();

    assign bus_a.in_valid  = in_valid;
    assign bus_a.mode      = mode;
    assign bus_a.data_in   = data_in;
    assign bus_a.out_ready = out_ready;
    assign bus_b.in_valid  = in_valid;
    assign bus_b.mode      = mode;
    assign bus_b.data_in   = data_in;
    assign bus_b.out_ready = out_ready;

    comp2s_pipe #(.N(N), .SAT(1'b1), .CNT_W(2)) dut_a (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus_a),
        .clr_cnt (clr_cnt),
        .ovf_cnt (ovf_cnt_a)
    );

    comp2s_pipe #(.N(N), .SAT(1'b0), .CNT_W(16)) dut_b (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus_b),
        .clr_cnt (clr_cnt),
        .ovf_cnt (ovf_cnt_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, got, exp);
        end
    endtask

    // Reference: {ovf, result} from the arithmetic definition.
    function automatic logic [N:0] ref_op(input logic [1:0] m, input logic [N-1:0] x, input bit sat);
        int           v;
        logic [N-1:0] r;
        logic         o;
        v = int'($signed(x));
        o = 1'b0;
        r = x;
        case (m)
            2'd1: begin
                if (v == -32768) begin o = 1'b1; r = sat ? 16'h7FFF : 16'h8000; end
                else r = 16'(-v);
            end
            2'd2: begin
                if (v == -32768) begin o = 1'b1; r = sat ? 16'h7FFF : 16'h8000; end
                else r = 16'(v < 0 ? -v : v);
            end
            2'd3: begin
                if (v == -32768) begin o = 1'b1; r = 16'hFFFF; end
                else if (v < 0) r = 16'h8000 | 16'(-v);
                else r = x;
            end
            default: r = x;
        endcase
        return {o, r};
    endfunction

    typedef struct {
        logic [1:0]   m;
        logic [N-1:0] x;
        int           c;
    } item_t;

    item_t      q[$];
    item_t      it;
    int         m_cnt_a = 0;
    int         m_cnt_b = 0;
    int         sz;
    logic       exp_ov;
    logic       exp_rdy;
    logic [N:0] ea;
    logic [N:0] eb;

    // Scoreboard: sampled mid-cycle, models the transfer at the next edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            q.delete();
            m_cnt_a = 0;
            m_cnt_b = 0;
            check("rst_out_valid_a", 32'(bus_a.out_valid), 0);
            check("rst_out_valid_b", 32'(bus_b.out_valid), 0);
            check("rst_data_out_a", 32'(bus_a.data_out), 0);
            check("rst_ovf_a", 32'(bus_a.ovf), 0);
            check("rst_cnt_a", 32'(ovf_cnt_a), 0);
            check("rst_cnt_b", 32'(ovf_cnt_b), 0);
        end else begin
            sz      = q.size();
            exp_rdy = (sz < 2) || out_ready;
            exp_ov  = 1'b0;
            if (sz > 0) exp_ov = ((cyc - q[0].c) >= 2);
            check("cnt_a", 32'(ovf_cnt_a), 32'(m_cnt_a));
            check("cnt_b", 32'(ovf_cnt_b), 32'(m_cnt_b));
            check("in_ready_a", 32'(bus_a.in_ready), 32'(exp_rdy));
            check("in_ready_b", 32'(bus_b.in_ready), 32'(exp_rdy));
            check("out_valid_a", 32'(bus_a.out_valid), 32'(exp_ov));
            check("out_valid_b", 32'(bus_b.out_valid), 32'(exp_ov));
            if (exp_ov) begin
                ea = ref_op(q[0].m, q[0].x, 1'b1);
                eb = ref_op(q[0].m, q[0].x, 1'b0);
                check("data_out_a", 32'(bus_a.data_out), 32'(ea[N-1:0]));
                check("ovf_a", 32'(bus_a.ovf), 32'(ea[N]));
                check("data_out_b", 32'(bus_b.data_out), 32'(eb[N-1:0]));
                check("ovf_b", 32'(bus_b.ovf), 32'(eb[N]));
            end
            if (clr_cnt) begin
                m_cnt_a = 0;
                m_cnt_b = 0;
            end else if (exp_ov && out_ready && ea[N]) begin
                if (m_cnt_a < 3) m_cnt_a++;
                if (m_cnt_b < 65535) m_cnt_b++;
            end
            if (exp_ov && out_ready) void'(q.pop_front());
            if (in_valid && exp_rdy) begin
                it.m = mode;
                it.x = data_in;
                it.c = cyc;
                q.push_back(it);
            end
        end
    end

    // Offer one sample until accepted; returns 1 ns after the accepting edge.
    task automatic send(input logic [1:0] m, input logic [N-1:0] x);
        logic rdy;
        int   k;
        in_valid = 1'b1;
        mode     = m;
        data_in  = x;
        rdy      = 1'b0;
        k        = 0;
        while (!rdy && k < 50) begin
            @(negedge clk);
            rdy = bus_a.in_ready;
            @(posedge clk);
            #1;
            k++;
        end
        if (!rdy) check("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    // Wait for a single result (out_ready=1, pipeline previously empty).
    task automatic expect_out(input string tag, input logic [N-1:0] exp_a,
                              input logic [N-1:0] exp_b, input logic exp_o);
        int waited;
        waited = 0;
        while (waited < 10) begin
            @(negedge clk);
            waited++;
            if (bus_a.out_valid) break;
        end
        check({tag, "_latency"}, 32'(waited), 2);
        check({tag, "_a"}, 32'(bus_a.data_out), 32'(exp_a));
        check({tag, "_b"}, 32'(bus_b.data_out), 32'(exp_b));
        check({tag, "_ovf"}, 32'(bus_a.ovf), 32'(exp_o));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;

        send(MODE_NEG, 16'h0005);  expect_out("neg_5", 16'hFFFB, 16'hFFFB, 1'b0);
        send(MODE_NEG, 16'h0000);  expect_out("neg_0", 16'h0000, 16'h0000, 1'b0);
        send(MODE_NEG, 16'h8000);  expect_out("neg_mn", 16'h7FFF, 16'h8000, 1'b1);
        check("cnt_after_neg_mn", 32'(ovf_cnt_a), 1);
        send(MODE_ABS, 16'hFFFB);  expect_out("abs_m5", 16'h0005, 16'h0005, 1'b0);
        send(MODE_SM, 16'hFFFB);   expect_out("sm_m5", 16'h8005, 16'h8005, 1'b0);
        send(MODE_SM, 16'h8000);   expect_out("sm_mn", 16'hFFFF, 16'hFFFF, 1'b1);
        send(MODE_PASS, 16'h1234); expect_out("pass", 16'h1234, 16'h1234, 1'b0);
        send(MODE_SM, 16'h0000);   expect_out("sm_0", 16'h0000, 16'h0000, 1'b0);

        // Counter saturation on the 2-bit instance.
        send(MODE_ABS, 16'h8000);  expect_out("abs_mn", 16'h7FFF, 16'h8000, 1'b1);
        check("cnt_a_3", 32'(ovf_cnt_a), 3);
        send(MODE_NEG, 16'h8000);  expect_out("neg_mn2", 16'h7FFF, 16'h8000, 1'b1);
        check("cnt_a_sat", 32'(ovf_cnt_a), 3);
        check("cnt_b_4", 32'(ovf_cnt_b), 4);

        // Clear coincident with an ovf delivery.
        send(MODE_NEG, 16'h8000);
        @(posedge clk); #1;
        clr_cnt = 1'b1;
        @(posedge clk); #1;
        clr_cnt = 1'b0;
        check("clr_coincident_a", 32'(ovf_cnt_a), 0);
        check("clr_coincident_b", 32'(ovf_cnt_b), 0);

        // Backpressure: two samples fill the pipeline, the third waits.
        out_ready = 1'b0;
        send(MODE_PASS, 16'h1111);
        send(MODE_NEG, 16'h2222);
        in_valid = 1'b1;
        mode     = MODE_ABS;
        data_in  = 16'hCCCD;
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready", 32'(bus_a.in_ready), 0);
            check("bp_out_valid", 32'(bus_a.out_valid), 1);
            check("bp_hold", 32'(bus_a.data_out), 32'h1111);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(MODE_ABS, 16'hCCCD);
        send(MODE_SM, 16'h8001);
        repeat (4) @(posedge clk);
        #1;

        // Randomised traffic with stalls, corner codes and occasional clears.
        for (int i = 0; i < 1500; i++) begin
            in_valid = ($urandom_range(0, 9) < 7);
            mode     = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0:       data_in = 16'h8000;
                1:       data_in = 16'h0000;
                2:       data_in = 16'h7FFF;
                3:       data_in = 16'hFFFF;
                default: data_in = 16'($urandom);
            endcase
            out_ready = ($urandom_range(0, 9) < 7);
            clr_cnt   = ($urandom_range(0, 63) == 0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        clr_cnt   = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Reset with both stages full.
        send(MODE_NEG, 16'h8000);  expect_out("pre_rst", 16'h7FFF, 16'h8000, 1'b1);
        check("pre_rst_cnt_nz", 32'(ovf_cnt_b != 16'd0), 1);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        mode      = MODE_NEG;
        data_in   = 16'h8000;
        repeat (3) @(posedge clk);
        @(posedge clk);
        #3;
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        check("rst_async_out_valid", 32'(bus_a.out_valid), 0);
        check("rst_async_data_out", 32'(bus_a.data_out), 0);
        check("rst_async_cnt_a", 32'(ovf_cnt_a), 0);
        check("rst_async_cnt_b", 32'(ovf_cnt_b), 0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        send(MODE_NEG, 16'h0005);  expect_out("post_rst", 16'hFFFB, 16'hFFFB, 1'b0);
        repeat (3) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
